// File: rtl/scanline_prefetch_if.sv
// rtl/scanline_prefetch_if.sv - memory read port between the scanline prefetcher and cell-state memory
interface scanline_prefetch_if #(
  parameter int ADDR_W = 15
) ();
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_grant;
  logic              rd_valid;
  logic [15:0]       rd_data;

  modport master (
    output rd_req,
    output rd_addr,
    input  rd_grant,
    input  rd_valid,
    input  rd_data
  );

  modport slave (
    input  rd_req,
    input  rd_addr,
    output rd_grant,
    output rd_valid,
    output rd_data
  );
endinterface

// File: rtl/scanline_prefetch.sv
// rtl/scanline_prefetch.sv - ping-pong line buffer: prefetches row+1 cells while row is shown, drives pixel colour
module scanline_prefetch #(
  parameter int         COLS        = 640,
  parameter int         ROWS        = 480,
  parameter int         ADDR_W      = 15,
  parameter logic [2:0] ALIVE_COLOR = 3'b010,
  parameter logic [2:0] DEAD_COLOR  = 3'b000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [8:0]                 row,
  input  logic [9:0]                 column,
  input  logic                       display_active,
  scanline_prefetch_if.master        mem,
  output logic [2:0]                 color,
  output logic                       fetch_overrun
);
  localparam int LINE_WORDS = COLS / 16;
  localparam int IDX_W      = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

  state_t            state;
  logic [8:0]        row_prev;
  logic [8:0]        target;
  logic [8:0]        pending;
  logic [IDX_W-1:0]  word_idx;
  logic [1:0]        valid;
  logic              rd_req_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [15:0]       line_buf [2][LINE_WORDS];

  logic              trig;
  logic              granted;
  logic              last_word;
  logic [8:0]        next_target;
  logic              launch;
  logic              launch_req;
  logic [8:0]        launch_target;

  function automatic logic [ADDR_W-1:0] addr_of(input logic [8:0] t, input logic [IDX_W-1:0] w);
    return ADDR_W'(int'(t) * LINE_WORDS + int'(w));
  endfunction

  // launch covers every way a fresh fetch begins; the REQ restart drops rd_req for one cycle
  always_comb begin
    trig          = (row != row_prev);
    next_target   = (int'(row) >= ROWS - 1) ? 9'd0 : row + 9'd1;
    granted       = rd_req_q && mem.rd_grant;
    last_word     = (int'(word_idx) == LINE_WORDS - 1);
    launch        = 1'b0;
    launch_req    = 1'b1;
    launch_target = next_target;
    case (state)
      IDLE:  launch = trig;
      REQ: begin
        launch     = trig && !granted;
        launch_req = 1'b0;
      end
      WAIT:  launch = trig && mem.rd_valid;
      DRAIN: begin
        launch = mem.rd_valid;
        if (!trig) launch_target = pending;
      end
      default: launch = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      row_prev      <= '0;
      target        <= '0;
      pending       <= '0;
      word_idx      <= '0;
      valid         <= '0;
      rd_req_q      <= 1'b0;
      rd_addr_q     <= '0;
      fetch_overrun <= 1'b0;
    end else begin
      row_prev <= row;
      case (state)
        REQ: begin
          if (trig) begin
            fetch_overrun <= 1'b1;
            if (granted) begin
              rd_req_q <= 1'b0;
              pending  <= next_target;
              state    <= DRAIN;
            end
          end else if (granted) begin
            rd_req_q <= 1'b0;
            state    <= WAIT;
          end else begin
            rd_req_q <= 1'b1;
          end
        end
        WAIT: begin
          if (mem.rd_valid) begin
            if (last_word) begin
              valid[target[0]] <= 1'b1;
              state            <= IDLE;
            end else begin
              if (trig) fetch_overrun <= 1'b1;
              word_idx  <= word_idx + IDX_W'(1);
              rd_req_q  <= 1'b1;
              rd_addr_q <= addr_of(target, word_idx + IDX_W'(1));
              state     <= REQ;
            end
          end else if (trig) begin
            fetch_overrun <= 1'b1;
            pending       <= next_target;
            state         <= DRAIN;
          end
        end
        DRAIN: begin
          if (trig) pending <= next_target;
        end
        default: ;
      endcase
      if (launch) begin
        valid[launch_target[0]] <= 1'b0;
        target                  <= launch_target;
        word_idx                <= '0;
        rd_req_q                <= launch_req;
        rd_addr_q               <= addr_of(launch_target, '0);
        state                   <= REQ;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == WAIT && mem.rd_valid) line_buf[target[0]][word_idx] <= mem.rd_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          color <= '0;
    else if (!display_active)                            color <= '0;
    else if (int'(column) >= COLS || !valid[row[0]])     color <= DEAD_COLOR;
    else if (line_buf[row[0]][column[9:4]][column[3:0]]) color <= ALIVE_COLOR;
    else                                                 color <= DEAD_COLOR;
  end

  assign mem.rd_req  = rd_req_q;
  assign mem.rd_addr = rd_addr_q;
endmodule

// File: tb/tb_scanline_prefetch.sv
// tb/tb_scanline_prefetch.sv - scoreboard bench for scanline_prefetch with a 2-cycle memory model
module tb_scanline_prefetch;
  localparam int         LW    = 40;
  localparam logic [2:0] ALIVE = 3'b010;
  localparam logic [2:0] DEAD  = 3'b000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [8:0] row;
  logic [9:0] column;
  logic       display_active;
  logic [2:0] color;
  logic       fetch_overrun;

  scanline_prefetch_if #(.ADDR_W(15)) bus ();

  scanline_prefetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .row            (row),
    .column         (column),
    .display_active (display_active),
    .mem            (bus),
    .color          (color),
    .fetch_overrun  (fetch_overrun)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         exp_addr_q[$];
  logic [2:0] exp_color_q[$];
  bit         outstanding, stall, manual, ovr_en;
  int         lat, g_addr, o_addr, ovr_addr, grants;
  logic [15:0] ovr_val;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] data_for(input int a);
    if (ovr_en && a == ovr_addr) return ovr_val;
    return 16'(a) ^ 16'hA5A5;
  endfunction

  // one clock: compare pending colour, retire the grant against the address scoreboard, run memory model
  task automatic tick();
    @(posedge clk);
    #1;
    if (exp_color_q.size() > 0) chk("color", color, exp_color_q.pop_front());
    if (bus.rd_grant) begin
      grants++;
      if (exp_addr_q.size() > 0) chk("rd_addr", g_addr, exp_addr_q.pop_front());
      else chk("spurious_req", exp_addr_q.size(), 1);
      outstanding = 1'b1;
      o_addr      = g_addr;
      lat         = 2;
    end
    bus.rd_grant = 1'b0;
    bus.rd_valid = 1'b0;
    if (outstanding) begin
      if (lat > 1) lat--;
      else if (!stall) begin
        bus.rd_valid = 1'b1;
        bus.rd_data  = data_for(o_addr);
        outstanding  = 1'b0;
      end
    end
    if (!manual && !outstanding && !bus.rd_valid && bus.rd_req) begin
      bus.rd_grant = 1'b1;
      g_addr       = int'(bus.rd_addr);
    end
  endtask

  task automatic push_line(input int t);
    for (int w = 0; w < LW; w++) exp_addr_q.push_back(t * LW + w);
  endtask

  task automatic pix(input int col, input bit de, input bit ok);
    logic [15:0] w;
    logic [2:0]  e;
    column         = 10'(col);
    display_active = de;
    if (!de) e = 3'b000;
    else if (col >= 640 || !ok) e = DEAD;
    else begin
      w = data_for(int'(row) * LW + col / 16);
      e = w[col % 16] ? ALIVE : DEAD;
    end
    exp_color_q.push_back(e);
    tick();
  endtask

  task automatic wait_done();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      tick();
      done = (exp_addr_q.size() == 0) && !outstanding && !bus.rd_valid && !bus.rd_req && !bus.rd_grant;
    end
    chk("fetch_done", done, 1);
    tick();
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    rst_n = 1'b0; row = '0; column = '0; display_active = 1'b0;
    bus.rd_grant = 1'b0; bus.rd_valid = 1'b0; bus.rd_data = '0;
    outstanding = 0; stall = 0; manual = 0; ovr_en = 0;
    lat = 0; g_addr = 0; o_addr = 0; ovr_addr = 0; ovr_val = '0; grants = 0;
    repeat (3) tick();
    chk("rst_color", color, 0);
    chk("rst_rd_req", bus.rd_req, 0);
    chk("rst_rd_addr", bus.rd_addr, 0);
    chk("rst_overrun", fetch_overrun, 0);
    rst_n = 1'b1;
    tick(); tick();

    // reset while a read is outstanding
    row = 9'd5;
    exp_addr_q.push_back(6 * LW);
    for (int i = 0; i < 20 && !outstanding; i++) tick();
    chk("mid_fetch_in_wait", outstanding, 1);
    rst_n = 1'b0; outstanding = 0; bus.rd_valid = 1'b0; bus.rd_grant = 1'b0; row = '0;
    tick();
    chk("mid_rst_rd_req", bus.rd_req, 0);
    chk("mid_rst_color", color, 0);
    chk("mid_rst_overrun", fetch_overrun, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // full line: row 0 -> 1 fetches row 2 (addresses 80..119)
    grants = 0;
    row = 9'd1; push_line(2);
    wait_done();
    chk("req_count", grants, 40);
    pix(0, 1, 0);

    ovr_en = 1; ovr_addr = 3 * LW; ovr_val = 16'h0001;
    row = 9'd2; push_line(3);
    for (int c = 0; c < 640; c += 53) pix(c, 1, 1);
    pix(639, 1, 1);
    wait_done();

    // pixel mapping on row 3 with word 0 = 0x0001
    row = 9'd3; push_line(4);
    for (int c = 0; c < 16; c++) pix(c, 1, 1);
    pix(650, 1, 1);
    pix(0, 0, 1);
    wait_done();
    ovr_en = 0;

    // frame wrap: last row prefetches row 0
    row = 9'd479; push_line(0);
    wait_done();
    row = 9'd0; push_line(1);
    for (int c = 0; c < 640; c += 91) pix(c, 1, 1);
    wait_done();

    // overrun: memory stalls while the row advances
    chk("overrun_clear", fetch_overrun, 0);
    stall = 1;
    row = 9'd1; exp_addr_q.push_back(2 * LW);
    for (int i = 0; i < 20 && !outstanding; i++) tick();
    repeat (20) tick();
    row = 9'd2; push_line(3);
    tick();
    chk("fetch_overrun", fetch_overrun, 1);
    for (int c = 0; c < 16; c++) pix(c, 1, 0);
    stall = 0;
    wait_done();
    row = 9'd3; push_line(4);
    for (int c = 0; c < 640; c += 73) pix(c, 1, 1);
    wait_done();

    // grant withheld: request must hold steady
    manual = 1;
    row = 9'd4; exp_addr_q.push_back(5 * LW);
    tick(); tick();
    for (int i = 0; i < 10; i++) begin
      chk("hold_rd_req", bus.rd_req, 1);
      chk("hold_rd_addr", bus.rd_addr, 5 * LW);
      tick();
    end
    // grant and trigger on the same edge
    bus.rd_grant = 1'b1; g_addr = int'(bus.rd_addr);
    row = 9'd5; push_line(6);
    manual = 0;
    wait_done();
    for (int c = 0; c < 8; c++) pix(c * 16, 1, 0);
    row = 9'd6; push_line(7);
    for (int c = 0; c < 640; c += 61) pix(c, 1, 1);
    wait_done();

    chk("addr_q_empty", exp_addr_q.size(), 0);
    chk("overrun_sticky", fetch_overrun, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/scanline_prefetch.md
Name: scanline_prefetch

Overview:
- Line-buffered cell fetcher between the cell-state memory port and the VGA colour output.
- While row r is displayed, it prefetches the packed cell bits for the next row into one bank of a ping-pong line buffer.
- The other bank serves per-pixel colour to the VGA pins.
- It consumes the VgaController timing (row, column, displayActive) and produces the 3-bit colour.

Parameters:
- COLS, 640, active pixels per line; must be a multiple of 16.
- ROWS, 480, active lines per frame.
- LINE_WORDS, COLS/16, 16-bit memory words per line.
- ADDR_W, 15, memory word address width.
- ALIVE_COLOR, 3'b010, colour driven for a live cell.
- DEAD_COLOR, 3'b000, colour driven for a dead cell or invalid line.

Ports:
- clk  in  1  pixel clock (clkDiv domain); sole clock.
- rst  in  1  asynchronous, active-low reset.
- row  in  9  current display row from the VGA timing.
- column  in  10  current display column from the VGA timing.
- displayActive  in  1  high inside the visible area.
- rdReq  out  1  memory read request; held until granted.
- rdAddr  out  ADDR_W  word address; stable while rdReq is high.
- rdGrant  in  1  request accepted this cycle.
- rdValid  in  1  read data valid, 1..N cycles after grant; one outstanding read only.
- rdData  in  16  packed cells; bit 0 is the leftmost pixel.
- color  out  3  registered pixel colour.
- fetchOverrun  out  1  sticky: a fetch was aborted by the next trigger.

Behaviour:
- Reset (rst low, async), all outputs and state:
  - color = 0, rdReq = 0, rdAddr = 0, fetchOverrun = 0.
  - Both bank-valid bits cleared.
  - FSM in IDLE; rowPrev = 0.
  - Buffer RAM contents are don't-care.
- Storage: two banks of LINE_WORDS x 16 bits. The display bank is row[0]; the fetch bank is target[0].
- Trigger: each cycle rowPrev <= row. A trigger fires when row != rowPrev.
  - target = row+1, or 0 when row == ROWS-1. Rows >= ROWS also yield target 0.
- Fetch FSM states: IDLE, REQ, WAIT, DRAIN.
  - IDLE, on trigger: clear valid[target[0]]; latch target; wordIdx = 0; go to REQ.
  - REQ: rdReq = 1, rdAddr = target*LINE_WORDS + wordIdx. When rdGrant is seen: rdReq drops next cycle; go to WAIT.
  - WAIT, on rdValid: write rdData to bank[target[0]][wordIdx].
    - If wordIdx == LINE_WORDS-1: set valid[target[0]]; go to IDLE.
    - Otherwise: wordIdx++; go to REQ.
  - Trigger while in REQ or WAIT: set fetchOverrun.
    - From REQ: if rdGrant is in the same cycle, go to DRAIN; otherwise drop rdReq and restart for the new target (REQ, wordIdx = 0).
    - From WAIT: go to DRAIN. DRAIN discards the next rdValid, then starts the pending target.
    - A new target arriving during DRAIN replaces the pending one.
  - Trigger in the same cycle as the final rdValid: the final word completes and valid is set, then the new fetch starts from IDLE semantics the next cycle. This is not an overrun.
- Address arithmetic is in ADDR_W bits. The maximum address is ROWS*LINE_WORDS-1 = 19199.
- Pixel path, 1-cycle latency. Colour at cycle t+1 reflects inputs at t:
  - !displayActive → 0.
  - column >= COLS, or valid[row[0]] == 0 → DEAD_COLOR.
  - Otherwise, bit column[3:0] of bank[row[0]][column[9:4]] selects ALIVE_COLOR or DEAD_COLOR.
- Same-bank read/write collision is impossible by construction: the fetch bank is (row+1)[0] ≠ row[0]. For row ROWS-1 → 0 with ROWS even, bank 0 ≠ bank 1.
- fetchOverrun clears only on reset.

Test Plan:
- Reset mid-fetch: assert rst low during WAIT → next edge shows rdReq = 0, color = 0, fetchOverrun = 0. The first trigger after release restarts at wordIdx 0.
- Full-line fetch: row 0→1 with a 2-cycle-latency memory model returning addr^16'hA5A5.
  - 40 requests issued, rdAddr 80..119.
  - valid[0] set after the 40th rdValid.
  - On row 2, color matches the model bits with 1-cycle latency.
- Pixel mapping: word 0 = 16'h0001 → column 0 gives ALIVE_COLOR (3'b010), columns 1..15 give 3'b000. Column 650 gives DEAD_COLOR. displayActive = 0 gives 3'b000.
- Frame wrap: row ROWS-1 (479) → rdAddr sequence 0..39 (target 0).
- Overrun: stall rdValid for one full line while row advances → fetchOverrun = 1 and the late rdValid is discarded.
  - The next fetch writes correct data.
  - The aborted bank stays invalid and shows DEAD_COLOR.
- Handshake hold: rdGrant held low for 10 cycles → rdReq and rdAddr stay stable. Grant and trigger in the same cycle → the next rdValid is discarded and the new target is fetched.
